telemetry_snapshot_reader: RTL and testbench
============================================

// Module: telemetry_snapshot_reader
// PURPOSE
//  Read-side responder for the core telemetry counters (mcycle, minstret, stall_cycles).
//  Accepts a read request and captures all three counters in the same cycle (atomic snapshot).
//  Streams the selected counter(s) over a narrow valid/ready response channel, low word first.
//  Sits between the counter block and the debug/CSR fabric.
// PARAMETERS
//  WIDTH   64  counter width; must be an integer multiple of BUS_W (elaboration-time assertion)
//  BUS_W   32  response data width
//  SNAP_W  16  width of the snapshot sequence counter
// PORTS
//  clk           in   1       clock
//  rst           in   1       synchronous reset, active-high
//  cnt_mcycle    in   WIDTH   live cycle counter
//  cnt_minstret  in   WIDTH   live retired-instruction counter
//  cnt_stall     in   WIDTH   live stall-cycle counter
//  req_valid     in   1       read request valid
//  req_ready     out  1       request accepted when req_valid && req_ready
//  req_sel       in   2       0=mcycle 1=minstret 2=stall 3=all three, in that order
//  rsp_valid     out  1       response beat valid
//  rsp_ready     in   1       response beat consumed when rsp_valid && rsp_ready
//  rsp_data      out  BUS_W   response word
//  rsp_last      out  1       final beat of the current response
//  busy          out  1       high while a response is outstanding
//  snap_seq      out  SNAP_W  count of accepted requests; wraps from 2^SNAP_W-1 to 0
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, busy=0, snap_seq=0.
//    All internal snapshot registers reset to 0.
//  - FSM states: IDLE, SEND.
//  - IDLE: req_ready=1 and rsp_valid=0. The cycle after reset deasserts, the block is in IDLE with req_ready=1.
//  - Accept in cycle N (req_valid && req_ready):
//      * register all three counter inputs as sampled at edge N, plus req_sel;
//      * snap_seq += 1;
//      * go to SEND.
//      rsp_valid=1 in N+1 (one-cycle latency), with the first beat on rsp_data.
//  - SEND: req_ready=0, busy=1.
//      * Beats per counter BPC = WIDTH/BUS_W. Total beats = BPC, or 3*BPC when req_sel=3.
//      * Beat k carries bits [k*BUS_W +: BUS_W] of the current counter.
//      * Counters are sent in order mcycle, minstret, stall.
//  - Handshake: rsp_data and rsp_last hold stable while rsp_valid && !rsp_ready.
//    The block advances one beat per rsp_valid && rsp_ready. Stalls of any length are allowed.
//  - rsp_last=1 only on the final beat. Its handshake returns the FSM to IDLE, and req_ready=1 the next cycle.
//    There is no back-to-back overlap of requests.
//  - req_valid during SEND is ignored (not accepted, no state change).
//  - Live counter changes during SEND never affect the in-flight response.
//  - WIDTH==BUS_W: one beat per counter, and rsp_last is on that beat when req_sel!=3.
//  - Reset asserted mid-SEND: the transfer is abandoned. All outputs return to reset values on the next edge.
//    No partial beat is replayed.
//  - Counter-side wrap: values are passed through verbatim. The reader performs no arithmetic on them.
// STRUCTURE
//  - telemetry_pkg holds:
//      * typedef enum logic [1:0] tel_sel_e {SEL_MCYCLE, SEL_MINSTRET, SEL_STALL, SEL_ALL};
//      * typedef enum logic tel_rd_state_e {RD_IDLE, RD_SEND};
//      * localparam TEL_NUM_CNT = 3.
//  - Sub-module telemetry_word_serializer holds the WIDTH-to-BUS_W beat mux and beat counter.
//    Its ports are load, advance, first/last flags and beat_data.
//    The top level owns the FSM, the snapshot registers, the counter-select index and snap_seq.
// TESTING
//  - Reset: hold rst 3 cycles -> all outputs 0. The first cycle after release gives req_ready=1, snap_seq=0.
//  - Single read: inputs mcycle=64'h0000_0001_DEAD_BEEF, sel=0, rsp_ready=1.
//    Expected: beats 32'hDEAD_BEEF then 32'h0000_0001 (last=1), snap_seq=1.
//  - Atomic all-read: sel=3 while all inputs keep incrementing every cycle.
//    Expected: 6 beats that equal the values sampled at the accept edge; rsp_last only on beat 6.
//  - Backpressure: rsp_ready=0 for 5 cycles on beat 2.
//    Expected: rsp_data and rsp_last are held constant and no beat is skipped.
//    req_valid pulsed in SEND is not accepted.
//  - Reset mid-SEND after beat 3 of sel=3 -> rsp_valid=0 on the next edge and snap_seq=0.
//    A new sel=1 request then returns a fresh minstret snapshot.
//  - Wrap: set snap_seq to 16'hFFFF via 65535 requests (or force), then one more request -> snap_seq=0.

Source files
------------

// File: rtl/telemetry_pkg.sv
// Shared types and constants for the telemetry snapshot reader.
package telemetry_pkg;

  typedef enum logic [1:0] {
    SEL_MCYCLE   = 2'd0,
    SEL_MINSTRET = 2'd1,
    SEL_STALL    = 2'd2,
    SEL_ALL      = 2'd3
  } tel_sel_e;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_SEND = 1'b1
  } tel_rd_state_e;

  localparam int TEL_NUM_CNT = 3;

endpackage

// File: rtl/telemetry_word_serializer.sv
// Splits one WIDTH-bit word into BUS_W-bit beats, low word first.
module telemetry_word_serializer #(
  parameter int WIDTH = 64,
  parameter int BUS_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             advance_i,
  input  logic [WIDTH-1:0] word_i,
  output logic             first_o,
  output logic             last_o,
  output logic [BUS_W-1:0] beat_data_o
);

  localparam int BPC    = WIDTH / BUS_W;
  localparam int BEAT_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPC - 1);

  logic [BEAT_W-1:0] beat_q, beat_d;

  assign first_o = (beat_q == '0);
  assign last_o  = (beat_q == LAST_BEAT);

  // Wrapping on the last beat lets the next counter start at beat 0 without a reload.
  always_comb begin
    beat_d = beat_q;
    if (load_i) begin
      beat_d = '0;
    end else if (advance_i) begin
      beat_d = last_o ? '0 : beat_q + BEAT_W'(1);
    end
  end

  always_comb begin
    beat_data_o = '0;
    for (int k = 0; k < BPC; k++) begin
      if (beat_q == BEAT_W'(k)) beat_data_o = word_i[k*BUS_W +: BUS_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) beat_q <= '0;
    else     beat_q <= beat_d;
  end

endmodule

// File: rtl/telemetry_snapshot_reader.sv
// Captures mcycle/minstret/stall atomically on request and streams them over a narrow valid/ready channel.
module telemetry_snapshot_reader
  import telemetry_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int BUS_W  = 32,
  parameter int SNAP_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  cnt_mcycle,
  input  logic [WIDTH-1:0]  cnt_minstret,
  input  logic [WIDTH-1:0]  cnt_stall,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [BUS_W-1:0]  rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic [SNAP_W-1:0] snap_seq
);

  if ((WIDTH % BUS_W) != 0 || WIDTH < BUS_W) begin : g_bad_width
    $error("WIDTH must be a nonzero integer multiple of BUS_W");
  end

  tel_rd_state_e     state_q, state_d;
  tel_sel_e          sel_q, sel_d;
  logic [1:0]        idx_q, idx_d;
  logic [SNAP_W-1:0] snap_seq_q, snap_seq_d;
  logic [WIDTH-1:0]  snap_mc_q, snap_mi_q, snap_st_q;
  logic              ready_en_q;
  logic              load_q;

  logic              load, advance, final_cnt;
  logic              ser_first, ser_last;
  logic [WIDTH-1:0]  cur_word;
  logic [BUS_W-1:0]  beat_data;

  always_comb begin
    case (idx_q)
      2'd0:    cur_word = snap_mc_q;
      2'd1:    cur_word = snap_mi_q;
      default: cur_word = snap_st_q;
    endcase
  end

  telemetry_word_serializer #(.WIDTH(WIDTH), .BUS_W(BUS_W)) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .advance_i   (advance),
    .word_i      (cur_word),
    .first_o     (ser_first),
    .last_o      (ser_last),
    .beat_data_o (beat_data)
  );

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    snap_seq_d = snap_seq_q;
    load       = 1'b0;
    advance    = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_data   = '0;
    rsp_last   = 1'b0;
    busy       = 1'b0;
    final_cnt  = (sel_q != SEL_ALL) || (idx_q == 2'(TEL_NUM_CNT - 1));
    case (state_q)
      RD_IDLE: begin
        // ready_en_q keeps req_ready low through reset and for the release edge itself.
        req_ready = ready_en_q;
        if (req_valid && ready_en_q) begin
          load       = 1'b1;
          sel_d      = tel_sel_e'(req_sel);
          idx_d      = (req_sel == SEL_ALL) ? 2'd0 : req_sel;
          snap_seq_d = snap_seq_q + SNAP_W'(1);
          state_d    = RD_SEND;
        end
      end
      RD_SEND: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        rsp_data  = beat_data;
        rsp_last  = ser_last && final_cnt;
        if (rsp_ready) begin
          advance = 1'b1;
          if (rsp_last)      state_d = RD_IDLE;
          else if (ser_last) idx_d   = idx_q + 2'd1;
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RD_IDLE;
      sel_q      <= SEL_MCYCLE;
      idx_q      <= 2'd0;
      snap_seq_q <= '0;
      snap_mc_q  <= '0;
      snap_mi_q  <= '0;
      snap_st_q  <= '0;
      ready_en_q <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      idx_q      <= idx_d;
      snap_seq_q <= snap_seq_d;
      ready_en_q <= 1'b1;
      load_q     <= load;
      if (load) begin
        snap_mc_q <= cnt_mcycle;
        snap_mi_q <= cnt_minstret;
        snap_st_q <= cnt_stall;
      end
    end
  end

  // A freshly loaded response must open on beat 0.
  always_ff @(posedge clk) begin
    if (!rst && load_q) assert (ser_first);
  end

  assign snap_seq = snap_seq_q;

endmodule

// File: tb/tb_telemetry_snapshot_reader.sv
// Directed bench for telemetry_snapshot_reader: default 64/32 instance plus a 32/32 instance with a 2-bit sequence counter.
module tb_telemetry_snapshot_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [63:0] cnt_mc, cnt_mi, cnt_st;
  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_last, busy;
  logic [1:0]  req_sel;
  logic [31:0] rsp_data;
  logic [15:0] snap_seq;

  logic [31:0] s_mc, s_mi, s_st;
  logic        s_req_valid, s_req_ready, s_rsp_valid, s_rsp_ready, s_rsp_last, s_busy;
  logic [1:0]  s_req_sel;
  logic [31:0] s_rsp_data;
  logic [1:0]  s_snap_seq;

  int          checks = 0;
  int          failures = 0;
  logic        inc_en = 1'b0;
  logic [63:0] em, ei, es;
  logic [31:0] exp_beats [6];

  telemetry_snapshot_reader dut (
    .clk(clk), .rst(rst),
    .cnt_mcycle(cnt_mc), .cnt_minstret(cnt_mi), .cnt_stall(cnt_st),
    .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .busy(busy), .snap_seq(snap_seq)
  );

  telemetry_snapshot_reader #(.WIDTH(32), .BUS_W(32), .SNAP_W(2)) u_small (
    .clk(clk), .rst(rst),
    .cnt_mcycle(s_mc), .cnt_minstret(s_mi), .cnt_stall(s_st),
    .req_valid(s_req_valid), .req_ready(s_req_ready), .req_sel(s_req_sel),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_data(s_rsp_data),
    .rsp_last(s_rsp_last), .busy(s_busy), .snap_seq(s_snap_seq)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (inc_en) begin
      cnt_mc = cnt_mc + 64'd1;
      cnt_mi = cnt_mi + 64'd3;
      cnt_st = cnt_st + 64'd1;
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_sel = 2'd0; rsp_ready = 1'b0;
    cnt_mc = '0; cnt_mi = '0; cnt_st = '0;
    s_mc = '0; s_mi = '0; s_st = '0; s_req_valid = 1'b0; s_req_sel = 2'd0; s_rsp_ready = 1'b1;

    // reset held for three edges
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data",  rsp_data, 0);
    chk("rst_rsp_last",  rsp_last, 0);
    chk("rst_busy",      busy, 0);
    chk("rst_snap_seq",  snap_seq, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_seq",   snap_seq, 0);

    // single mcycle read
    cnt_mc = 64'h0000_0001_DEAD_BEEF; req_sel = 2'd0; req_valid = 1'b1; rsp_ready = 1'b1;
    step(); req_valid = 1'b0;
    chk("single_valid", rsp_valid, 1);
    chk("single_b0",    rsp_data, 32'hDEAD_BEEF);
    chk("single_last0", rsp_last, 0);
    chk("single_busy",  busy, 1);
    chk("single_rdy",   req_ready, 0);
    chk("single_seq",   snap_seq, 1);
    step();
    chk("single_b1",    rsp_data, 32'h0000_0001);
    chk("single_last1", rsp_last, 1);
    step();
    chk("single_done_valid", rsp_valid, 0);
    chk("single_done_busy",  busy, 0);
    chk("single_done_rdy",   req_ready, 1);

    // atomic all-read with live counters ticking every cycle
    cnt_mc = 64'h0000_0002_FFFF_FFFF; cnt_mi = 64'h0000_0010_FFFF_FFFE; cnt_st = 64'h0000_0000_FFFF_FFFF;
    em = cnt_mc; ei = cnt_mi; es = cnt_st;
    req_sel = 2'd3; req_valid = 1'b1; inc_en = 1'b1;
    step(); req_valid = 1'b0;
    exp_beats = '{em[31:0], em[63:32], ei[31:0], ei[63:32], es[31:0], es[63:32]};
    for (int k = 0; k < 6; k++) begin
      chk("all_data", rsp_data, exp_beats[k]);
      chk("all_last", rsp_last, (k == 5));
      step();
    end
    inc_en = 1'b0;
    chk("all_done_valid", rsp_valid, 0);
    chk("all_seq", snap_seq, 2);

    // backpressure on beat 2 with a stray request during SEND
    cnt_mc = 64'h0123_4567_89AB_CDEF; cnt_mi = 64'hFEDC_BA98_7654_3210; cnt_st = 64'h0F0F_0F0F_F0F0_F0F0;
    exp_beats = '{32'h89AB_CDEF, 32'h0123_4567, 32'h7654_3210, 32'hFEDC_BA98, 32'hF0F0_F0F0, 32'h0F0F_0F0F};
    req_sel = 2'd3; req_valid = 1'b1;
    step(); req_valid = 1'b0;
    chk("bp_b0", rsp_data, exp_beats[0]);
    step();
    rsp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_data", rsp_data, exp_beats[1]);
      chk("bp_hold_last", rsp_last, 0);
      chk("bp_hold_rdy",  req_ready, 0);
      req_valid = 1'b1; req_sel = 2'd0;
      step();
    end
    req_valid = 1'b0;
    chk("bp_seq_unchanged", snap_seq, 3);
    rsp_ready = 1'b1;
    for (int k = 1; k < 6; k++) begin
      chk("bp_data", rsp_data, exp_beats[k]);
      chk("bp_last", rsp_last, (k == 5));
      step();
    end
    chk("bp_done_valid", rsp_valid, 0);
    chk("bp_done_seq",   snap_seq, 3);

    // reset after beat 3 of an all-read
    cnt_mc = 64'hAAAA_0000_BBBB_0001; cnt_mi = 64'h5555_6666_7777_8888; cnt_st = 64'h9999_0000_1111_0000;
    req_sel = 2'd3; req_valid = 1'b1;
    step(); req_valid = 1'b0;
    exp_beats = '{32'hBBBB_0001, 32'hAAAA_0000, 32'h7777_8888, 32'h5555_6666, 32'h1111_0000, 32'h9999_0000};
    for (int k = 0; k < 3; k++) begin
      chk("mid_data", rsp_data, exp_beats[k]);
      step();
    end
    rst = 1'b1;
    step();
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_data",  rsp_data, 0);
    chk("mid_rst_last",  rsp_last, 0);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_rdy",   req_ready, 0);
    chk("mid_rst_seq",   snap_seq, 0);
    rst = 1'b0;
    step();
    chk("mid_rel_rdy", req_ready, 1);
    cnt_mi = 64'h1111_2222_3333_4444; req_sel = 2'd1; req_valid = 1'b1;
    step(); req_valid = 1'b0;
    chk("fresh_b0",    rsp_data, 32'h3333_4444);
    chk("fresh_last0", rsp_last, 0);
    chk("fresh_seq",   snap_seq, 1);
    step();
    chk("fresh_b1",    rsp_data, 32'h1111_2222);
    chk("fresh_last1", rsp_last, 1);
    step();
    chk("fresh_done",  rsp_valid, 0);

    // WIDTH == BUS_W instance: single-beat counters and sequence wrap
    s_st = 32'hABCD_0123; s_req_sel = 2'd2; s_req_valid = 1'b1;
    step(); s_req_valid = 1'b0;
    chk("sm_stall_data", s_rsp_data, 32'hABCD_0123);
    chk("sm_stall_last", s_rsp_last, 1);
    chk("sm_seq1",       s_snap_seq, 1);
    step();
    chk("sm_idle", s_rsp_valid, 0);
    s_mc = 32'h0000_0011; s_mi = 32'h0000_0022; s_st = 32'h0000_0033; s_req_sel = 2'd3; s_req_valid = 1'b1;
    step(); s_req_valid = 1'b0;
    chk("sm_all_b0", s_rsp_data, 32'h0000_0011);
    chk("sm_all_l0", s_rsp_last, 0);
    step();
    chk("sm_all_b1", s_rsp_data, 32'h0000_0022);
    chk("sm_all_l1", s_rsp_last, 0);
    step();
    chk("sm_all_b2", s_rsp_data, 32'h0000_0033);
    chk("sm_all_l2", s_rsp_last, 1);
    chk("sm_seq2",   s_snap_seq, 2);
    step();
    s_req_sel = 2'd0; s_req_valid = 1'b1;
    step(); s_req_valid = 1'b0;
    chk("sm_seq3", s_snap_seq, 3);
    step();
    s_req_valid = 1'b1;
    step(); s_req_valid = 1'b0;
    chk("sm_seq_wrap", s_snap_seq, 0);
    chk("sm_wrap_data", s_rsp_data, 32'h0000_0011);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
